// File: rtl/microwave_ctrl_pkg.sv
// Shared definitions for the microwave cooking-cycle controller: state
// encodings, state width and default parameter values.
package microwave_ctrl_pkg;

  localparam int unsigned StateWidth     = 3;
  localparam int unsigned DefaultTw      = 4;
  localparam int unsigned DefaultBeepLen = 8;

  typedef enum logic [StateWidth-1:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/microwave_ctrl_tick_down_counter.sv
// tick_down_counter: loadable down counter with enable and clear. It never
// wraps below zero; is_one_o flags the last count before reaching zero.
module tick_down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             is_one_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear beats load beats decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == Width'(1));

endmodule

// File: rtl/microwave_ctrl.sv
// microwave_ctrl: cooking-cycle controller. Latches a cook time, runs the
// magnetron while counting down on tick, pauses on door/cancel and beeps for
// BEEP_LEN cycles at the end of cooking.
// Optional feature macro: MICROWAVE_POWER_LEVEL_EN adds a `power` input that
// duty-cycles the magnetron over a 4-tick window.
module microwave_ctrl
  import microwave_ctrl_pkg::*;
#(
  parameter int unsigned TW       = DefaultTw,
  parameter int unsigned BEEP_LEN = DefaultBeepLen
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [TW-1:0]         time_in,
  input  logic                  load,
  input  logic                  start,
  input  logic                  cancel,
  input  logic                  door_open,
`ifdef MICROWAVE_POWER_LEVEL_EN
  input  logic [1:0]            power,
`endif
  output logic [TW-1:0]         remaining,
  output logic                  mag_on,
  output logic                  lamp,
  output logic                  beep,
  output logic [StateWidth-1:0] state
);

  localparam int unsigned BeepW = $clog2(BEEP_LEN + 1);
  localparam logic [BeepW-1:0] BeepLoad = BeepW'(BEEP_LEN);

  state_e state_q, state_d;
  logic   mag_on_q, mag_on_d;
  logic   beep_q, beep_d;
  logic   run_power_ok;

  // Remaining-time counter controls.
  logic          rem_clr, rem_load, rem_en, rem_is_one;
  logic [TW-1:0] rem_count;

  // Beep timer controls.
  logic             bt_clr, bt_load, bt_en, bt_is_one;
  logic [BeepW-1:0] bt_count;

  tick_down_counter #(
    .Width (TW)
  ) u_remaining (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (rem_clr),
    .load_i     (rem_load),
    .load_val_i (time_in),
    .en_i       (rem_en),
    .count_o    (rem_count),
    .is_one_o   (rem_is_one)
  );

  tick_down_counter #(
    .Width (BeepW)
  ) u_beep_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (bt_clr),
    .load_i     (bt_load),
    .load_val_i (BeepLoad),
    .en_i       (bt_en),
    .count_o    (bt_count),
    .is_one_o   (bt_is_one)
  );

  // Next-state and counter control. Inputs are resolved in the order
  // cancel > door_open > start > load > tick; an input with no effect in the
  // current state falls through to the next one.
  always_comb begin
    state_d  = state_q;
    rem_clr  = 1'b0;
    rem_load = 1'b0;
    rem_en   = 1'b0;
    bt_clr   = 1'b0;
    bt_load  = 1'b0;
    bt_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cancel) begin
          rem_clr = 1'b1;
        end else if (load && (time_in != '0)) begin
          rem_load = 1'b1;
          state_d  = StSet;
        end
      end
      StSet: begin
        if (cancel) begin
          rem_clr = 1'b1;
          state_d = StIdle;
        end else if (start && !door_open && (rem_count != '0)) begin
          state_d = StRun;
        end else if (load) begin
          if (time_in == '0) begin
            rem_clr = 1'b1;
            state_d = StIdle;
          end else begin
            rem_load = 1'b1;
          end
        end
      end
      StRun: begin
        // A tick coinciding with door/cancel is dropped.
        if (cancel || door_open) begin
          state_d = StPause;
        end else if (tick) begin
          rem_en = 1'b1;
          if (rem_is_one) begin
            state_d = StDone;
            bt_load = 1'b1;
          end
        end
      end
      StPause: begin
        if (cancel) begin
          rem_clr = 1'b1;
          state_d = StIdle;
        end else if (!door_open && start && (rem_count != '0)) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (cancel || door_open || bt_is_one || (bt_count == '0)) begin
          bt_clr  = 1'b1;
          state_d = StIdle;
        end else begin
          bt_en = 1'b1;
        end
      end
      default: begin
        rem_clr = 1'b1;
        bt_clr  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

`ifdef MICROWAVE_POWER_LEVEL_EN
  logic [1:0] phase_q, phase_d;
  logic [1:0] power_q, power_d;

  // Power level latches with an accepted load; phase restarts on SET->RUN and
  // advances on every accepted RUN tick, so it holds still in PAUSE.
  always_comb begin
    phase_d = phase_q;
    power_d = power_q;
    if (rem_load) begin
      power_d = power;
    end
    if ((state_q == StSet) && (state_d == StRun)) begin
      phase_d = '0;
    end else if (rem_en) begin
      phase_d = phase_q + 2'd1;
    end
  end

  // Power level and tick phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      power_q <= '0;
    end else begin
      phase_q <= phase_d;
      power_q <= power_d;
    end
  end

  assign run_power_ok = (phase_d <= power_q);
`else
  assign run_power_ok = 1'b1;
`endif

  // Registered outputs follow the state being entered.
  always_comb begin
    mag_on_d = (state_d == StRun) && run_power_ok;
    beep_d   = (state_d == StDone);
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mag_on_q <= 1'b0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_on_q <= mag_on_d;
      beep_q   <= beep_d;
    end
  end

  assign remaining = rem_count;
  assign mag_on    = mag_on_q;
  assign beep      = beep_q;
  assign state     = state_q;
  assign lamp      = door_open | (state_q == StRun);

endmodule
